// File: rtl/serial_audio_pkg.sv
// Shared types and constants for the serial audio receiver.
package serial_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rxState_e;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SLOT_W = 16;

  // Bit counter spans a whole frame of two slots.
  function automatic int cntWidth(input int slotW);
    return $clog2(2 * slotW);
  endfunction

endpackage

// File: rtl/serial_audio_rx_if.sv
// Serial input pair plus the sample/error outputs that feed the equalizer.
interface serial_audio_rx_if
  import serial_audio_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ERR_W  = 8
) ();

  logic              SFS;
  logic              SDI;
  logic [DATA_W-1:0] D;
  logic              LR;
  logic              D_valid;
  logic              frame_err;
  logic [ERR_W-1:0]  err_cnt;

  // Source side: drives the serial stream, observes samples.
  modport master (
    output SFS, SDI,
    input  D, LR, D_valid, frame_err, err_cnt
  );

  // Receiver side.
  modport slave (
    input  SFS, SDI,
    output D, LR, D_valid, frame_err, err_cnt
  );

endinterface

// File: rtl/serial_shift_reg.sv
// Serial-in/parallel-out shift register, MSB arrives first.
module serial_shift_reg
  import serial_audio_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              shift_en_i,
  input  logic              sdi_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q, data_d;

  // Clear and shift may coincide: the new bit lands in a zeroed register.
  always_comb begin
    data_d = data_q;
    if (clr_i) data_d = '0;
    if (shift_en_i) data_d = {data_d[DATA_W-2:0], sdi_i};
  end

  // Register the shifted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_audio_rx.sv
// Frame-synchronous serial audio receiver: deserializes left/right slots
// into parallel samples with a valid strobe and mid-frame sync detection.
module serial_audio_rx
  import serial_audio_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int ERR_W  = 8
) (
  input  logic               SCK,
  input  logic               reset_n,
  serial_audio_rx_if.slave   bus
);

  localparam int CNT_W = cntWidth(SLOT_W);
  localparam logic [CNT_W-1:0] LEFT_LAST  = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] RIGHT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_BASE  = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_BITS  = CNT_W'(DATA_W);

  rxState_e          state_q, state_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0]  slotPos;
  logic              shiftEn, shiftClr, syncErr;
  logic              slotDone_q, slotDone_d;
  logic              slotLr_q, slotLr_d;
  logic [DATA_W-1:0] shiftData;

  logic [DATA_W-1:0] D_q;
  logic              LR_q, valid_q, err_q;
  logic [ERR_W-1:0]  errCnt_q;

  // Next-state logic: a sync pulse always restarts the frame at the left MSB,
  // and flags an error if a frame was already in progress.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shiftEn    = 1'b0;
    shiftClr   = 1'b0;
    syncErr    = 1'b0;
    slotDone_d = 1'b0;
    slotLr_d   = LR_LEFT;
    slotPos    = (state_q == RIGHT) ? (bitCnt_q - SLOT_BASE) : bitCnt_q;
    if (bus.SFS) begin
      syncErr  = (state_q != IDLE);
      state_d  = LEFT;
      bitCnt_d = CNT_W'(1);
      shiftClr = 1'b1;
      shiftEn  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LEFT: begin
          shiftEn  = (slotPos < DATA_BITS);
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == LEFT_LAST) begin
            state_d    = RIGHT;
            slotDone_d = 1'b1;
            slotLr_d   = LR_LEFT;
          end
        end
        RIGHT: begin
          shiftEn  = (slotPos < DATA_BITS);
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == RIGHT_LAST) begin
            state_d    = IDLE;
            bitCnt_d   = '0;
            slotDone_d = 1'b1;
            slotLr_d   = LR_RIGHT;
          end
        end
        default: begin
          state_d  = IDLE;
          bitCnt_d = '0;
        end
      endcase
    end
  end

  // FSM, bit counter and the one-cycle slot-complete marker.
  always_ff @(posedge SCK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      slotDone_q <= 1'b0;
      slotLr_q   <= LR_LEFT;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      slotDone_q <= slotDone_d;
      slotLr_q   <= slotLr_d;
    end
  end

  serial_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk        (SCK),
    .rst_n      (reset_n),
    .clr_i      (shiftClr),
    .shift_en_i (shiftEn),
    .sdi_i      (bus.SDI),
    .data_o     (shiftData)
  );

  // Output registers: the sample is published one cycle after its last bit,
  // so the shift register's pre-edge contents are the completed word.
  always_ff @(posedge SCK or negedge reset_n) begin
    if (!reset_n) begin
      D_q      <= '0;
      LR_q     <= LR_LEFT;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      valid_q <= slotDone_q;
      err_q   <= syncErr;
      if (slotDone_q) begin
        D_q  <= shiftData;
        LR_q <= slotLr_q;
      end
      if (syncErr && (errCnt_q != '1)) errCnt_q <= errCnt_q + 1'b1;
    end
  end

  assign bus.D         = D_q;
  assign bus.LR        = LR_q;
  assign bus.D_valid   = valid_q;
  assign bus.frame_err = err_q;
  assign bus.err_cnt   = errCnt_q;

endmodule

// File: tb/tb_serial_audio_rx.sv
// Self-checking bench for serial_audio_rx with a frame-position reference model.
module tb_serial_audio_rx;
  import serial_audio_pkg::*;

  localparam int DATA_W = 16;
  localparam int SLOT_W = 16;
  localparam int ERR_W  = 8;
  localparam int OBS_W  = DATA_W + 3 + ERR_W;

  logic SCK = 1'b0;
  logic reset_n = 1'b0;

  serial_audio_rx_if #(.DATA_W(DATA_W), .ERR_W(ERR_W)) bus ();

  serial_audio_rx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .ERR_W(ERR_W)) dut (
    .SCK     (SCK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 SCK = ~SCK;

  int total = 0;
  int bad   = 0;

  // Reference model state: position within the frame (-1 when waiting for sync)
  int               pos = -1;
  int               mSlot, mBit;
  logic [DATA_W-1:0] word [2];
  logic [DATA_W-1:0] expD = '0, pendD = '0;
  logic             expLr = 1'b0, pendLr = 1'b0;
  logic             expValid = 1'b0, pendValid = 1'b0, expErr = 1'b0;
  logic [ERR_W-1:0] expCnt = '0;

  logic sfsQ[$];
  logic sdiQ[$];
  int   vIdx[$];
  logic [DATA_W-1:0] vD[$];
  logic vLr[$];

  // Behavioural model: a slot's word is known once its last bit arrives and
  // appears on the outputs one cycle later.
  always @(posedge SCK or negedge reset_n) begin
    if (!reset_n) begin
      pos = -1; expD = '0; expLr = 1'b0; expValid = 1'b0; expErr = 1'b0;
      expCnt = '0; pendValid = 1'b0; pendD = '0; pendLr = 1'b0;
    end else begin
      expValid = pendValid;
      if (pendValid) begin
        expD  = pendD;
        expLr = pendLr;
      end
      pendValid = 1'b0;
      expErr    = 1'b0;
      if (bus.SFS) begin
        if (pos >= 0) begin
          expErr = 1'b1;
          if (expCnt != {ERR_W{1'b1}}) expCnt = expCnt + 1'b1;
        end
        pos = 0;
      end else if (pos >= 0) begin
        pos = pos + 1;
      end
      if (pos >= 0) begin
        mSlot = pos / SLOT_W;
        mBit  = pos % SLOT_W;
        if (mBit < DATA_W) word[mSlot][DATA_W-1-mBit] = bus.SDI;
        if (mBit == SLOT_W - 1) begin
          pendValid = 1'b1;
          pendD     = word[mSlot];
          pendLr    = (mSlot == 1);
        end
        if (pos == 2 * SLOT_W - 1) pos = -1;
      end
    end
  end

  function automatic logic [OBS_W-1:0] obsNow();
    return {bus.D, bus.LR, bus.D_valid, bus.frame_err, bus.err_cnt};
  endfunction

  function automatic logic [OBS_W-1:0] expNow();
    return {expD, expLr, expValid, expErr, expCnt};
  endfunction

  task automatic step(input logic sfs, input logic sdi);
    bus.SFS = sfs;
    bus.SDI = sdi;
    @(posedge SCK);
    #2;
  endtask

  task automatic pushFrame(input logic [SLOT_W-1:0] l, input logic [SLOT_W-1:0] r);
    for (int i = 0; i < 2 * SLOT_W; i++) begin
      sfsQ.push_back(i == 0);
      sdiQ.push_back(i < SLOT_W ? l[SLOT_W-1-i] : r[2*SLOT_W-1-i]);
    end
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) begin
      sfsQ.push_back(1'b0);
      sdiQ.push_back(1'($urandom));
    end
  endtask

  task automatic clearQueues();
    sfsQ.delete(); sdiQ.delete(); vIdx.delete(); vD.delete(); vLr.delete();
  endtask

  task automatic doReset();
    bus.SFS = 1'b0;
    bus.SDI = 1'b0;
    @(negedge SCK);
    reset_n = 1'b0;
    @(negedge SCK);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.SFS = 1'b0;
    bus.SDI = 1'b0;
    reset_n = 1'b0;
    #12;
    total++;
    if (obsNow() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_values got=%h exp=%h", obsNow(), {OBS_W{1'b0}});
    end
    @(negedge SCK);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'($urandom));
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL idle_no_sync i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
    end
  endtask

  task automatic test_single_frame();
    int errSeen = 0;
    clearQueues();
    pushFrame(16'hA55A, 16'h1234);
    pushIdle(3);
    for (int i = 0; i < sfsQ.size(); i++) begin
      step(sfsQ[i], sdiQ[i]);
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL single_frame i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
      if (bus.D_valid) begin vIdx.push_back(i); vD.push_back(bus.D); vLr.push_back(bus.LR); end
      if (bus.frame_err) errSeen++;
    end
    total++;
    if (vIdx.size() !== 2) begin
      bad++;
      $display("[TB] FAIL single_frame_count got=%0d exp=2", vIdx.size());
    end else begin
      total++;
      if ({vIdx[0], vD[0], vLr[0]} !== {32'd16, 16'hA55A, 1'b0}) begin
        bad++;
        $display("[TB] FAIL single_left got idx=%0d D=%h LR=%b exp idx=16 D=a55a LR=0", vIdx[0], vD[0], vLr[0]);
      end
      total++;
      if ({vIdx[1], vD[1], vLr[1]} !== {32'd32, 16'h1234, 1'b1}) begin
        bad++;
        $display("[TB] FAIL single_right got idx=%0d D=%h LR=%b exp idx=32 D=1234 LR=1", vIdx[1], vD[1], vLr[1]);
      end
    end
    total++;
    if (errSeen !== 0) begin
      bad++;
      $display("[TB] FAIL single_frame_err got=%0d exp=0", errSeen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want [6];
    want[0] = 16'h0000; want[1] = 16'hFFFF; want[2] = 16'h7FFF; want[3] = 16'h8000;
    want[4] = 16'($urandom); want[5] = 16'($urandom);
    clearQueues();
    for (int f = 0; f < 3; f++) pushFrame(want[2*f], want[2*f+1]);
    pushIdle(3);
    for (int i = 0; i < sfsQ.size(); i++) begin
      step(sfsQ[i], sdiQ[i]);
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL back_to_back i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
      if (bus.D_valid) begin vIdx.push_back(i); vD.push_back(bus.D); vLr.push_back(bus.LR); end
    end
    total++;
    if (vIdx.size() !== 6) begin
      bad++;
      $display("[TB] FAIL b2b_count got=%0d exp=6", vIdx.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if ({vIdx[k], vD[k], vLr[k]} !== {16 * (k + 1), want[k], 1'(k % 2)}) begin
          bad++;
          $display("[TB] FAIL b2b_sample k=%0d got idx=%0d D=%h LR=%b exp idx=%0d D=%h LR=%0d",
                   k, vIdx[k], vD[k], vLr[k], 16 * (k + 1), want[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_mid_frame_err();
    int errIdx[$];
    doReset();
    clearQueues();
    sfsQ.push_back(1'b1); sdiQ.push_back(1'($urandom));
    for (int i = 1; i < 7; i++) begin sfsQ.push_back(1'b0); sdiQ.push_back(1'($urandom)); end
    pushFrame(16'hBEEF, 16'hCAFE);
    pushIdle(3);
    for (int i = 0; i < sfsQ.size(); i++) begin
      step(sfsQ[i], sdiQ[i]);
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL mid_frame_err i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
      if (bus.D_valid) begin vIdx.push_back(i); vD.push_back(bus.D); vLr.push_back(bus.LR); end
      if (bus.frame_err) errIdx.push_back(i);
    end
    total++;
    if (errIdx.size() !== 1 || errIdx[0] !== 7) begin
      bad++;
      $display("[TB] FAIL mid_err_pulse got count=%0d exp count=1 at i=7", errIdx.size());
    end
    total++;
    if (bus.err_cnt !== 8'd1) begin
      bad++;
      $display("[TB] FAIL mid_err_cnt got=%h exp=01", bus.err_cnt);
    end
    total++;
    if (vIdx.size() !== 2) begin
      bad++;
      $display("[TB] FAIL mid_err_valid_count got=%0d exp=2", vIdx.size());
    end else begin
      total++;
      if ({vIdx[0], vD[0], vIdx[1], vD[1]} !== {32'd23, 16'hBEEF, 32'd39, 16'hCAFE}) begin
        bad++;
        $display("[TB] FAIL mid_err_samples got %0d:%h %0d:%h exp 23:beef 39:cafe", vIdx[0], vD[0], vIdx[1], vD[1]);
      end
    end
  endtask

  task automatic test_err_after_left();
    logic [15:0] l0, nl, nr;
    l0 = 16'($urandom); nl = 16'($urandom); nr = 16'($urandom);
    clearQueues();
    pushFrame(l0, 16'($urandom));
    for (int i = 0; i < SLOT_W; i++) begin void'(sfsQ.pop_back()); void'(sdiQ.pop_back()); end
    pushFrame(nl, nr);
    pushIdle(3);
    for (int i = 0; i < sfsQ.size(); i++) begin
      step(sfsQ[i], sdiQ[i]);
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL err_after_left i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
      if (i == 16) begin
        total++;
        if ({bus.D_valid, bus.frame_err, bus.D, bus.LR} !== {1'b1, 1'b1, l0, 1'b0}) begin
          bad++;
          $display("[TB] FAIL both_strobes got V=%b E=%b D=%h LR=%b exp V=1 E=1 D=%h LR=0",
                   bus.D_valid, bus.frame_err, bus.D, bus.LR, l0);
        end
      end
      if (bus.D_valid) begin vIdx.push_back(i); vD.push_back(bus.D); vLr.push_back(bus.LR); end
    end
    total++;
    if (vIdx.size() !== 3) begin
      bad++;
      $display("[TB] FAIL err_after_left_count got=%0d exp=3", vIdx.size());
    end else begin
      total++;
      if ({vD[1], vLr[1], vD[2], vLr[2]} !== {nl, 1'b0, nr, 1'b1}) begin
        bad++;
        $display("[TB] FAIL err_after_left_new got %h/%b %h/%b exp %h/0 %h/1", vD[1], vLr[1], vD[2], vLr[2], nl, nr);
      end
    end
  endtask

  task automatic test_saturate();
    int errs = 0;
    doReset();
    for (int i = 0; i < 304; i++) begin
      step(i < 301, 1'($urandom));
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL saturate i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
      if (bus.frame_err) errs++;
    end
    total++;
    if (bus.err_cnt !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL saturate_cnt got=%h exp=ff", bus.err_cnt);
    end
    total++;
    if (errs !== 300) begin
      bad++;
      $display("[TB] FAIL saturate_pulses got=%0d exp=300", errs);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] nl;
    clearQueues();
    pushFrame(16'($urandom), 16'($urandom));
    for (int i = 0; i <= SLOT_W + 10; i++) begin
      step(sfsQ[i], sdiQ[i]);
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL pre_reset i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (obsNow() !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%h exp=%h", obsNow(), {OBS_W{1'b0}});
    end
    @(negedge SCK);
    reset_n = 1'b1;
    nl = 16'($urandom);
    clearQueues();
    pushIdle(10);
    pushFrame(nl, 16'($urandom));
    pushIdle(2);
    for (int i = 0; i < sfsQ.size(); i++) begin
      step(sfsQ[i], sdiQ[i]);
      total++;
      if (obsNow() !== expNow()) begin
        bad++;
        $display("[TB] FAIL post_reset i=%0d got=%h exp=%h", i, obsNow(), expNow());
      end
      if (bus.D_valid) begin vIdx.push_back(i); vD.push_back(bus.D); vLr.push_back(bus.LR); end
    end
    total++;
    if (vIdx.size() < 1 || {vIdx[0], vD[0], vLr[0]} !== {32'd26, nl, 1'b0}) begin
      bad++;
      $display("[TB] FAIL post_reset_first got count=%0d exp first valid at i=26 D=%h LR=0", vIdx.size(), nl);
    end
  endtask

  initial begin
    bus.SFS = 1'b0;
    bus.SDI = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_frame_err();
    test_err_after_left();
    test_saturate();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
